// File: rtl/hdr_fields_decode_pkg.sv
// Shared field layout and route encodings for the 64-bit router flit header decoder.
package hdr_fields_decode_pkg;

  localparam int PKT_W = 64;
  localparam int RSV_W = 5;
  localparam int HOP_W = 4;
  localparam int SRC_W = 8;
  localparam int PAY_W = 32;

  localparam int VC_B    = 63;
  localparam int DX_B    = 62;
  localparam int DY_B    = 61;
  localparam int RSV_HI  = 60;
  localparam int HX_HI   = 55;
  localparam int HY_HI   = 51;
  localparam int SRCX_HI = 47;
  localparam int SRCY_HI = 39;

  typedef logic [4:0] dir_t;

  // One-hot order is {local, south, north, west, east}.
  localparam dir_t DIR_E = 5'b00001;
  localparam dir_t DIR_W = 5'b00010;
  localparam dir_t DIR_N = 5'b00100;
  localparam dir_t DIR_S = 5'b01000;
  localparam dir_t DIR_L = 5'b10000;

endpackage

// File: rtl/hdr_fields_decode_if.sv
// Flit-at-buffer-head bus: header word plus its valid qualifier.
interface hdr_fields_decode_if;
  import hdr_fields_decode_pkg::*;

  logic [PKT_W-1:0] pkt;
  logic             pkt_valid;

  modport master (output pkt, output pkt_valid);
  modport slave  (input  pkt, input  pkt_valid);
endinterface

// File: rtl/hdr_fields_decode_xy_route_calc.sv
// Dimension-order (X first, then Y) route selection; purely combinational.
module xy_route_calc
  import hdr_fields_decode_pkg::*;
(
  input  logic             dx,
  input  logic             dy,
  input  logic [HOP_W-1:0] hx,
  input  logic [HOP_W-1:0] hy,
  output dir_t             dir
);

  always_comb begin
    if (hx != '0)      dir = dx ? DIR_W : DIR_E;
    else if (hy != '0) dir = dy ? DIR_S : DIR_N;
    else               dir = DIR_L;
  end

endmodule

// File: rtl/hdr_fields_decode.sv
// Header field extractor with a registered XY route request.
// Optional registered next-hop flit is built when HDR_FIELDS_NEXT_PKT_EN is defined.
module hdr_fields_decode
  import hdr_fields_decode_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  hdr_fields_decode_if.slave  in_if,
  output logic                vc,
  output logic                dx,
  output logic                dy,
  output logic [RSV_W-1:0]    rsv,
  output logic [HOP_W-1:0]    hx,
  output logic [HOP_W-1:0]    hy,
  output logic [SRC_W-1:0]    srcx,
  output logic [SRC_W-1:0]    srcy,
  output logic [PAY_W-1:0]    payload,
  output logic                route_vld,
  output dir_t                route_dir
`ifdef HDR_FIELDS_NEXT_PKT_EN
  ,
  output logic [PKT_W-1:0]    next_pkt
`endif
);

  // Field slices bypass the clock and reset entirely.
  assign vc      = in_if.pkt[VC_B];
  assign dx      = in_if.pkt[DX_B];
  assign dy      = in_if.pkt[DY_B];
  assign rsv     = in_if.pkt[RSV_HI  -: RSV_W];
  assign hx      = in_if.pkt[HX_HI   -: HOP_W];
  assign hy      = in_if.pkt[HY_HI   -: HOP_W];
  assign srcx    = in_if.pkt[SRCX_HI -: SRC_W];
  assign srcy    = in_if.pkt[SRCY_HI -: SRC_W];
  assign payload = in_if.pkt[PAY_W-1:0];

  dir_t dir_calc;

  xy_route_calc u_route (
    .dx  (dx),
    .dy  (dy),
    .hx  (hx),
    .hy  (hy),
    .dir (dir_calc)
  );

  logic route_vld_d, route_vld_q;
  dir_t route_dir_d, route_dir_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    route_vld_d = in_if.pkt_valid;
    route_dir_d = route_dir_q;
    if (in_if.pkt_valid) route_dir_d = dir_calc;
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_vld_q <= 1'b0;
      route_dir_q <= '0;
    end else begin
      route_vld_q <= route_vld_d;
      route_dir_q <= route_dir_d;
    end
  end

  assign route_vld = route_vld_q;
  assign route_dir = route_dir_q;

`ifdef HDR_FIELDS_NEXT_PKT_EN
  logic [PKT_W-1:0] next_pkt_d, next_pkt_q;

  // Only the hop count of the axis actually taken is consumed; a local route passes through.
  always_comb begin
    next_pkt_d = next_pkt_q;
    if (in_if.pkt_valid) begin
      next_pkt_d = in_if.pkt;
      if (dir_calc == DIR_E || dir_calc == DIR_W)
        next_pkt_d[HX_HI -: HOP_W] = hx - HOP_W'(1);
      else if (dir_calc == DIR_N || dir_calc == DIR_S)
        next_pkt_d[HY_HI -: HOP_W] = hy - HOP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) next_pkt_q <= '0;
    else        next_pkt_q <= next_pkt_d;
  end

  assign next_pkt = next_pkt_q;
`endif

endmodule

// File: tb/tb_hdr_fields_decode.sv
// Self-checking bench for hdr_fields_decode; define HDR_FIELDS_NEXT_PKT_EN to also check next_pkt.
module tb_hdr_fields_decode;
  import hdr_fields_decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hdr_fields_decode_if bus ();

  logic             vc, dx, dy;
  logic [4:0]       rsv;
  logic [3:0]       hx, hy;
  logic [7:0]       srcx, srcy;
  logic [31:0]      payload;
  logic             route_vld;
  logic [4:0]       route_dir;
`ifdef HDR_FIELDS_NEXT_PKT_EN
  logic [63:0]      next_pkt;
`endif

  hdr_fields_decode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (bus),
    .vc        (vc),
    .dx        (dx),
    .dy        (dy),
    .rsv       (rsv),
    .hx        (hx),
    .hy        (hy),
    .srcx      (srcx),
    .srcy      (srcy),
    .payload   (payload),
    .route_vld (route_vld),
    .route_dir (route_dir)
`ifdef HDR_FIELDS_NEXT_PKT_EN
    ,
    .next_pkt  (next_pkt)
`endif
  );

  typedef struct packed {
    logic        vld;
    logic [4:0]  dir;
    logic [63:0] nxt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [4:0]  held_dir;
  logic [63:0] held_nxt;

  function automatic logic [4:0] model_dir(input logic [63:0] p);
    if (p[55:52] != 4'd0)      return p[62] ? 5'b00010 : 5'b00001;
    else if (p[51:48] != 4'd0) return p[61] ? 5'b01000 : 5'b00100;
    else                       return 5'b10000;
  endfunction

  function automatic logic [63:0] model_nxt(input logic [63:0] p);
    logic [63:0] r;
    r = p;
    if (p[55:52] != 4'd0)      r[55:52] = p[55:52] - 4'd1;
    else if (p[51:48] != 4'd0) r[51:48] = p[51:48] - 4'd1;
    return r;
  endfunction

  // Drive one cycle at the negedge, push the expected request, sample #1 after the posedge.
  task automatic drive(input logic [63:0] p, input logic v);
    exp_t e;
    @(negedge clk);
    bus.pkt = p;
    bus.pkt_valid = v;
    if (v) begin
      held_dir = model_dir(p);
      held_nxt = model_nxt(p);
    end
    e.vld = v;
    e.dir = held_dir;
    e.nxt = held_nxt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string name);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, no expected entry", name);
      return;
    end
    e = sb_q.pop_front();
    if (route_vld !== e.vld || route_dir !== e.dir) begin
      n_err++;
      $display("FAIL %s: got vld=%b dir=%b, want vld=%b dir=%b", name, route_vld, route_dir, e.vld, e.dir);
    end
`ifdef HDR_FIELDS_NEXT_PKT_EN
    n_cmp++;
    if (next_pkt !== e.nxt) begin
      n_err++;
      $display("FAIL %s next_pkt: got %h want %h", name, next_pkt, e.nxt);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pkt = 64'h0123_4567_89AB_CDEF;
    bus.pkt_valid = 1'b1;
    held_dir = 5'b0;
    held_nxt = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (route_vld !== 1'b0 || route_dir !== 5'b0) begin
      n_err++;
      $display("FAIL reset_state: got vld=%b dir=%b, want vld=0 dir=00000", route_vld, route_dir);
    end
`ifdef HDR_FIELDS_NEXT_PKT_EN
    n_cmp++;
    if (next_pkt !== 64'h0) begin
      n_err++;
      $display("FAIL reset_next_pkt: got %h want 0", next_pkt);
    end
`endif
    n_cmp++;
    if (payload !== 32'h89AB_CDEF || srcx !== 8'h45) begin
      n_err++;
      $display("FAIL fields_in_reset: got payload=%h srcx=%h, want 89abcdef 45", payload, srcx);
    end
    @(negedge clk);
    bus.pkt_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fields();
    @(negedge clk);
    bus.pkt_valid = 1'b0;
    bus.pkt = 64'h8A33_0101_DEAD_BEEF;
    #1;
    n_cmp++;
    if ({vc, dx, dy, rsv, hx, hy} !== {1'b1, 1'b0, 1'b0, 5'b01010, 4'h3, 4'h3}) begin
      n_err++;
      $display("FAIL fields_hdr: got vc=%b dx=%b dy=%b rsv=%b hx=%h hy=%h, want 1 0 0 01010 3 3",
               vc, dx, dy, rsv, hx, hy);
    end
    n_cmp++;
    if (srcx !== 8'h01 || srcy !== 8'h01 || payload !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL fields_src: got srcx=%h srcy=%h payload=%h, want 01 01 deadbeef", srcx, srcy, payload);
    end
    bus.pkt = 64'h5F00_A5C3_0000_0001;
    #1;
    n_cmp++;
    if ({vc, dx, dy, rsv, hx, hy, srcx, srcy} !== {1'b0, 1'b1, 1'b0, 5'b11111, 4'h0, 4'h0, 8'hA5, 8'hC3}) begin
      n_err++;
      $display("FAIL fields_alt: got vc=%b dx=%b dy=%b rsv=%b hx=%h hy=%h sx=%h sy=%h",
               vc, dx, dy, rsv, hx, hy, srcx, srcy);
    end
  endtask

  task automatic test_routes();
    drive(64'h8A33_0101_DEAD_BEEF, 1'b1);
    n_cmp++;
    if (route_dir !== DIR_E) begin
      n_err++;
      $display("FAIL route_east_const: got %b want %b", route_dir, DIR_E);
    end
`ifdef HDR_FIELDS_NEXT_PKT_EN
    n_cmp++;
    if (next_pkt !== 64'h8A23_0101_DEAD_BEEF) begin
      n_err++;
      $display("FAIL next_east_const: got %h want 8a230101deadbeef", next_pkt);
    end
`endif
    pop_cmp("route_east");
    drive(64'h4003_0000_0000_0000, 1'b1);  // dx=1 but hx=0, dy=0: north
    pop_cmp("route_y_north");
    drive(64'h2003_0000_0000_0000, 1'b1);
    pop_cmp("route_south");
    drive(64'h4030_1234_0000_0000, 1'b1);
    pop_cmp("route_west");
    drive(64'hDF00_1234_5678_9ABC, 1'b1);
    n_cmp++;
    if (route_dir !== DIR_L) begin
      n_err++;
      $display("FAIL route_local_const: got %b want %b", route_dir, DIR_L);
    end
    pop_cmp("route_local");
  endtask

  task automatic test_hold();
    drive(64'h0021_0000_0000_0000, 1'b1);
    pop_cmp("hold_setup");
    for (int i = 0; i < 3; i++) begin
      drive({$urandom, $urandom}, 1'b0);
      pop_cmp("hold_idle");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      drive({$urandom, $urandom}, 1'b1);
      pop_cmp("b2b");
    end
    drive(64'h0, 1'b0);
    pop_cmp("b2b_tail");
  endtask

  task automatic test_async_reset();
    drive(64'h0F50_0000_0000_0000, 1'b1);
    pop_cmp("async_setup");
    @(negedge clk);
    bus.pkt = 64'h0005_0000_0000_0000;
    bus.pkt_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (route_vld !== 1'b0 || route_dir !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset: got vld=%b dir=%b before edge, want 0 00000", route_vld, route_dir);
    end
    @(negedge clk);
    bus.pkt_valid = 1'b0;
    rst_n = 1'b1;
    held_dir = 5'b0;
    held_nxt = 64'h0;
    drive(64'h0005_0000_0000_0000, 1'b0);
    pop_cmp("async_no_replay");
  endtask

  initial begin
    bus.pkt = '0;
    bus.pkt_valid = 1'b0;
    test_reset();
    test_fields();
    test_routes();
    test_hold();
    test_back_to_back();
    test_async_reset();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
